// File: rtl/ntsc_fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ntsc_fb_pkg                                                |
// | Purpose : Shared types and defaults for the NTSC framebuffer reader. |
// |           Holds the fetch FSM encoding, default framebuffer geometry |
// |           and base address, the underflow colour, and the pixel      |
// |           address helper.                                            |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package ntsc_fb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } fetch_state_e;

   localparam logic [19:0] DEF_BASE_ADDR = 20'h00000;
   localparam int unsigned DEF_H_PIX     = 320;
   localparam int unsigned DEF_V_PIX     = 240;
   localparam logic [7:0]  DEF_UFLOW_RGB = 8'hE0;

   // SRAM address of a linear pixel index; the sum wraps at 20 bits.
   function automatic logic [19:0] pix_addr(input logic [19:0] base,
                                            input logic [16:0] idx);
      return base + {3'b000, idx};
   endfunction

endpackage : ntsc_fb_pkg
`default_nettype wire

// File: rtl/ntsc_fb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ntsc_fb_fifo                                               |
// | Purpose : Small synchronous FIFO for prefetched pixels. Supports a   |
// |           push and a pop in the same cycle, a synchronous flush, and |
// |           reports occupancy, empty and full. Head is read            |
// |           combinationally (first-word fall-through).                 |
// | Ports   : clk, rst         clock / sync active-high reset            |
// |           flush            empty the FIFO (overrides push/pop)       |
// |           push, wdata      write one word                            |
// |           pop              discard head word                         |
// |           rdata            current head word                         |
// |           count            occupancy 0..2^AW                         |
// |           empty, full      status flags                              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ntsc_fb_fifo #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          full
);

   localparam logic [AW:0] c_depth = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] mem_q [2**AW];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          w_do_push;
   logic          w_do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == c_depth);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // A push into a full FIFO is accepted only when a pop frees the slot.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (w_do_pop && !w_do_push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule : ntsc_fb_fifo
`default_nettype wire

// File: rtl/ntsc_fb_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ntsc_fb_reader                                             |
// | Purpose : Framebuffer scan-out. Walks SRAM in raster order through   |
// |           the sram_ctrl read handshake, prefetches into a FIFO and   |
// |           pops one byte onto rgb per new active pixel. Restarts the  |
// |           walk on the leading edge of vsync.                         |
// | Ports   : clk, rst               clock / sync active-high reset      |
// |           x, active_video, vsync timing from ntsc                    |
// |           mem, rw, addr          request to sram_ctrl                |
// |           ready, data2fpga       sram_ctrl handshake / read data     |
// |           rgb                    registered pixel colour             |
// |           uflow                  sticky underflow flag               |
// |           uflow_cnt              saturating underflow counter        |
// |                                  (only with NTSC_FB_UFLOW_CNT_EN)    |
// | Config  : `define NTSC_FB_UFLOW_CNT_EN adds the uflow_cnt output.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ntsc_fb_reader
   import ntsc_fb_pkg::*;
#(
   parameter logic [19:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int unsigned H_PIX     = DEF_H_PIX,
   parameter int unsigned V_PIX     = DEF_V_PIX,
   parameter int unsigned FIFO_AW   = 4,
   parameter logic        VS_POL    = 1'b0,
   parameter logic [7:0]  UFLOW_RGB = DEF_UFLOW_RGB
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  x,
   input  logic        active_video,
   input  logic        vsync,
   output logic        mem,
   output logic        rw,
   output logic [19:0] addr,
   input  logic        ready,
   input  logic [7:0]  data2fpga,
   output logic [7:0]  rgb,
`ifdef NTSC_FB_UFLOW_CNT_EN
   output logic [15:0] uflow_cnt,
`endif
   output logic        uflow
);

   localparam logic [16:0]      c_frame_pix = 17'(H_PIX * V_PIX);
   localparam logic [FIFO_AW:0] c_depth_m1  = {1'b0, {FIFO_AW{1'b1}}};

   fetch_state_e state_q, state_d;
   logic [16:0]  fetch_idx_q, fetch_idx_d;
   logic         mem_q, mem_d;
   logic [19:0]  addr_q, addr_d;
   logic         tag_q, tag_d;      // outstanding read belongs to the old frame

   logic [9:0]   x_q;
   logic         active_q;
   logic         vs_q;
   logic [7:0]   rgb_q;
   logic         uflow_q;

   logic         w_vs_start;
   logic         w_pix_adv;
   logic         w_inflight;
   logic         w_room;
   logic         w_push;
   logic         w_pop;
   logic [7:0]   w_head;
   logic [FIFO_AW:0] w_count;
   logic         w_empty;
   logic         w_full;

   assign rw   = 1'b1;
   assign mem  = mem_q;
   assign addr = addr_q;
   assign rgb  = rgb_q;
   assign uflow = uflow_q;

   // vs_q resets to the inactive level so a vsync held active through
   // reset is still seen as a frame start.
   assign w_vs_start = (vsync == VS_POL) && (vs_q != VS_POL);
   assign w_pix_adv  = active_video && ((x != x_q) || !active_q);
   assign w_pop      = w_pix_adv && !w_empty;

   // Occupancy plus the read still in flight must leave a free slot.
   assign w_inflight = (state_q == ST_WAIT);
   assign w_room     = w_inflight ? (w_count < c_depth_m1) : !w_full;

   ntsc_fb_fifo #(
      .AW (FIFO_AW),
      .DW (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (w_vs_start),
      .push  (w_push),
      .wdata (data2fpga),
      .pop   (w_pop),
      .rdata (w_head),
      .count (w_count),
      .empty (w_empty),
      .full  (w_full)
   );

   // ---------------- fetch FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         fetch_idx_q <= '0;
         mem_q       <= 1'b0;
         addr_q      <= '0;
         tag_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_idx_q <= fetch_idx_d;
         mem_q       <= mem_d;
         addr_q      <= addr_d;
         tag_q       <= tag_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      fetch_idx_d = fetch_idx_q;
      mem_d       = mem_q;
      addr_d      = addr_q;
      tag_d       = tag_q;
      w_push      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!w_vs_start && w_room && (fetch_idx_q < c_frame_pix)) begin
               state_d = ST_REQ;
               mem_d   = 1'b1;
               addr_d  = pix_addr(BASE_ADDR, fetch_idx_q);
            end
         end
         ST_REQ: begin
            // An accept on the sync cycle still owes a data beat; tag it.
            if (ready) begin
               state_d = ST_WAIT;
               mem_d   = 1'b0;
               tag_d   = w_vs_start;
            end else if (w_vs_start) begin
               state_d = ST_IDLE;
               mem_d   = 1'b0;
            end
         end
         ST_WAIT: begin
            if (ready) begin
               state_d = ST_IDLE;
               tag_d   = 1'b0;
               if (!tag_q && !w_vs_start) begin
                  w_push      = 1'b1;
                  fetch_idx_d = fetch_idx_q + 1'b1;
               end
            end else if (w_vs_start) begin
               tag_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            mem_d   = 1'b0;
            tag_d   = 1'b0;
         end
      endcase
      if (w_vs_start) begin
         fetch_idx_d = '0;
      end
   end

   // ---------------- pixel output ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q      <= '0;
         active_q <= 1'b0;
         vs_q     <= ~VS_POL;
         rgb_q    <= '0;
         uflow_q  <= 1'b0;
      end else begin
         x_q      <= x;
         active_q <= active_video;
         vs_q     <= vsync;
         if (w_pix_adv) begin
            if (!w_empty) begin
               rgb_q <= w_head;
            end else begin
               rgb_q   <= UFLOW_RGB;
               uflow_q <= 1'b1;
            end
         end else if (!active_video) begin
            rgb_q <= '0;
         end
      end
   end

`ifdef NTSC_FB_UFLOW_CNT_EN
   logic [15:0] uflow_cnt_q;

   assign uflow_cnt = uflow_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         uflow_cnt_q <= '0;
      end else if (w_pix_adv && w_empty && (uflow_cnt_q != 16'hFFFF)) begin
         uflow_cnt_q <= uflow_cnt_q + 1'b1;
      end
   end
`endif

endmodule : ntsc_fb_reader
`default_nettype wire

// File: tb/tb_ntsc_fb_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ntsc_fb_reader                                          |
// | Purpose : Directed self-checking bench for ntsc_fb_reader. Instance  |
// |           A uses default geometry; instance B uses a 24-pixel frame  |
// |           at BASE_ADDR 20'hFFFF0 for exhaustion and address wrap.    |
// |           Each instance talks to a behavioural sram_ctrl whose data  |
// |           is addr[7:0]. Honors NTSC_FB_UFLOW_CNT_EN.                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_ntsc_fb_reader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // ---------------- instance A ----------------
   logic [9:0]  x_a = '0;
   logic        act_a = 1'b0;
   logic        vs_a = 1'b1;
   logic        mem_a, rw_a, uflow_a;
   logic [19:0] addr_a;
   logic [7:0]  rgb_a;
   logic        ready_a;
   logic [7:0]  data_a;
`ifdef NTSC_FB_UFLOW_CNT_EN
   logic [15:0] ucnt_a, ucnt_b;
`endif

   ntsc_fb_reader u_dut_a (
      .clk(clk), .rst(rst), .x(x_a), .active_video(act_a), .vsync(vs_a),
      .mem(mem_a), .rw(rw_a), .addr(addr_a), .ready(ready_a),
      .data2fpga(data_a), .rgb(rgb_a),
`ifdef NTSC_FB_UFLOW_CNT_EN
      .uflow_cnt(ucnt_a),
`endif
      .uflow(uflow_a)
   );

   // ---------------- instance B ----------------
   logic [9:0]  x_b = '0;
   logic        act_b = 1'b0;
   logic        vs_b = 1'b1;
   logic        mem_b, rw_b, uflow_b;
   logic [19:0] addr_b;
   logic [7:0]  rgb_b;
   logic        ready_b;
   logic [7:0]  data_b;

   ntsc_fb_reader #(
      .BASE_ADDR(20'hFFFF0), .H_PIX(8), .V_PIX(3)
   ) u_dut_b (
      .clk(clk), .rst(rst), .x(x_b), .active_video(act_b), .vsync(vs_b),
      .mem(mem_b), .rw(rw_b), .addr(addr_b), .ready(ready_b),
      .data2fpga(data_b), .rgb(rgb_b),
`ifdef NTSC_FB_UFLOW_CNT_EN
      .uflow_cnt(ucnt_b),
`endif
      .uflow(uflow_b)
   );

   // ---------------- sram_ctrl models ----------------
   // ready drops after an accept for lat cycles, then returns with data.
   int          lat_a = 2;
   logic        busy_a, busy_b;
   int          cnt_a, cnt_b;
   logic [7:0]  pend_a, pend_b;
   logic [19:0] log_a[$];
   logic [19:0] log_b[$];

   always @(posedge clk) begin
      if (rst) begin
         ready_a <= 1'b1; busy_a <= 1'b0; cnt_a <= 0; data_a <= '0; pend_a <= '0;
      end else if (busy_a) begin
         if (cnt_a == 0) begin
            ready_a <= 1'b1; busy_a <= 1'b0; data_a <= pend_a;
         end else begin
            cnt_a <= cnt_a - 1;
         end
      end else if (mem_a && ready_a) begin
         ready_a <= 1'b0; busy_a <= 1'b1; cnt_a <= lat_a - 1; pend_a <= addr_a[7:0];
         log_a.push_back(addr_a);
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         ready_b <= 1'b1; busy_b <= 1'b0; cnt_b <= 0; data_b <= '0; pend_b <= '0;
      end else if (busy_b) begin
         if (cnt_b == 0) begin
            ready_b <= 1'b1; busy_b <= 1'b0; data_b <= pend_b;
         end else begin
            cnt_b <= cnt_b - 1;
         end
      end else if (mem_b && ready_b) begin
         ready_b <= 1'b0; busy_b <= 1'b1; cnt_b <= 0; pend_b <= addr_b[7:0];
         log_b.push_back(addr_b);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   logic [7:0] exp_next;
   int         uf_seen;
   int         n;

   initial begin
      // ---- reset ----
      tick(3);
      chk("rst_mem",   mem_a,   1'b0);
      chk("rst_addr",  addr_a,  20'h0);
      chk("rst_rgb",   rgb_a,   8'h00);
      chk("rst_uflow", uflow_a, 1'b0);
      chk("rst_rw",    rw_a,    1'b1);
`ifdef NTSC_FB_UFLOW_CNT_EN
      chk("rst_ucnt",  ucnt_a,  16'h0);
`endif
      rst = 1'b0;

      // ---- prefetch fills FIFO, then idles ----
      tick(150);
      chk("p1_nreq",   log_a.size(), 16);
      chk("p1_first",  log_a[0],  20'h00000);
      chk("p1_seven",  log_a[7],  20'h00007);
      chk("p1_last",   log_a[15], 20'h0000F);
      chk("p1_idle",   mem_a,  1'b0);
      chk("p1_addr",   addr_a, 20'h0000F);
      chk("p1_uflow",  uflow_a, 1'b0);
      chk("p1_rgb",    rgb_a, 8'h00);

      // ---- active line, x every 4 cycles ----
      for (int k = 0; k < 16; k++) begin
         x_a = 10'(k); act_a = 1'b1;
         tick(1);
         chk("p2_rgb", rgb_a, 32'(k));
         tick(3);
         chk("p2_hold", rgb_a, 32'(k));
      end
      act_a = 1'b0; x_a = '0;
      tick(1);
      chk("p2_blank", rgb_a, 8'h00);
      chk("p2_uflow", uflow_a, 1'b0);

      // ---- refill, then slow SRAM with fast pixels -> underflow ----
      tick(120);
      lat_a = 10;
      exp_next = 8'd16;
      uf_seen = 0;
      for (int k = 0; k < 48; k++) begin
         x_a = 10'(100 + k); act_a = 1'b1;
         tick(1);
         if (k < 16) begin
            chk("p3_prefetched", rgb_a, 32'(16 + k));
            exp_next = exp_next + 8'd1;
         end else begin
            tests++;
            assert ((rgb_a === exp_next) || (rgb_a === 8'hE0)) else begin
               fails++;
               $error("FAIL p3_rgb: got %0h expected %0h or e0", rgb_a, exp_next);
            end
            if (rgb_a === 8'hE0) uf_seen++;
            else exp_next = exp_next + 8'd1;
         end
         tick(1);
      end
      act_a = 1'b0;
      tick(2);
      chk("p3_uflow_set", uflow_a, 1'b1);
      chk("p3_some_uflow", (uf_seen > 0), 1'b1);
      chk("p3_blank", rgb_a, 8'h00);
`ifdef NTSC_FB_UFLOW_CNT_EN
      chk("p3_ucnt", ucnt_a, 32'(uf_seen));
`endif

      // ---- vsync while a read is in flight ----
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (mem_a && ready_a) break;
      end
      tick(1);                       // request accepted; now in WAIT
      n = log_a.size();
      vs_a = 1'b0;
      tick(3);
      vs_a = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (log_a.size() > n) break;
         tick(1);
      end
      chk("p4_nreq", log_a.size(), n + 1);
      if (log_a.size() > n) chk("p4_restart_addr", log_a[n], 20'h00000);
      chk("p4_uflow_sticky", uflow_a, 1'b1);
      lat_a = 2;
      tick(120);
      x_a = 10'd5; act_a = 1'b1;
      tick(1);
      chk("p4_pix0", rgb_a, 8'h00);
      x_a = 10'd6;
      tick(1);
      chk("p4_pix1", rgb_a, 8'h01);
      x_a = 10'd7;
      tick(1);
      chk("p4_pix2", rgb_a, 8'h02);
      act_a = 1'b0;

      // ---- instance B: wrap and end of frame ----
      x_b = 10'd1; act_b = 1'b1;
      tick(1);
      chk("b_pix0", rgb_b, 8'hF0);
      for (int k = 2; k < 150; k++) begin
         x_b = 10'(k);
         tick(1);
      end
      act_b = 1'b0;
      tick(2);
      chk("b_nreq", log_b.size(), 24);
      chk("b_first", log_b[0],  20'hFFFF0);
      chk("b_pre_wrap", log_b[15], 20'hFFFFF);
      chk("b_wrap", log_b[16], 20'h00000);
      chk("b_last", log_b[23], 20'h00007);
      tick(50);
      chk("b_eof_nreq", log_b.size(), 24);
      chk("b_eof_mem", mem_b, 1'b0);
      vs_b = 1'b0;
      tick(1);
      vs_b = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (log_b.size() > 24) break;
         tick(1);
      end
      chk("b_vs_nreq", log_b.size(), 25);
      if (log_b.size() > 24) chk("b_vs_addr", log_b[24], 20'hFFFF0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_ntsc_fb_reader
`default_nettype wire
